// File: rtl/bypass_net.sv
// Operand forwarding network: per-port priority select across in-flight stages,
// writeback and a short writeback history. Optional perf counters: BYPASS_PERF_EN.
module bypass_net #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned N_RD   = 2,
  parameter int unsigned N_STG  = 3,
  parameter int unsigned HIST_D = 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [N_RD*REG_W-1:0]   rd_addr_i,
  input  logic [N_RD*DATA_W-1:0]  rf_data_i,
  input  logic [N_STG-1:0]        stg_we_i,
  input  logic [N_STG-1:0]        stg_rdy_i,
  input  logic [N_STG*REG_W-1:0]  stg_dst_i,
  input  logic [N_STG*DATA_W-1:0] stg_data_i,
  input  logic                    wb_we_i,
  input  logic [REG_W-1:0]        wb_dst_i,
  input  logic [DATA_W-1:0]       wb_data_i,
  output logic [N_RD*DATA_W-1:0]  bypass_o,
  output logic [N_RD-1:0]         fwd_hit_o,
  output logic                    stall_o
`ifdef BYPASS_PERF_EN
  ,
  output logic [31:0]             perf_fwd_cnt_o,
  output logic [31:0]             perf_stall_cnt_o
`endif
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [HIST_D-1:0] hist_vld_q, hist_vld_d;
  logic [REG_W-1:0]  hist_dst_q  [HIST_D];
  logic [REG_W-1:0]  hist_dst_d  [HIST_D];
  logic [DATA_W-1:0] hist_data_q [HIST_D];
  logic [DATA_W-1:0] hist_data_d [HIST_D];

  logic [N_RD*DATA_W-1:0] bypass_c;
  logic [N_RD-1:0]        hit_c;
  logic [N_RD-1:0]        pend_c;

  // History shift: entry 0 captures this cycle's writeback; x0 writes are never valid.
  always_comb begin : hist_next
    hist_vld_d     = '0;
    hist_vld_d[0]  = wb_we_i & (wb_dst_i != '0);
    hist_dst_d[0]  = wb_dst_i;
    hist_data_d[0] = wb_data_i;
    for (int k = 1; k < int'(HIST_D); k++) begin
      hist_vld_d[k]  = hist_vld_q[k-1];
      hist_dst_d[k]  = hist_dst_q[k-1];
      hist_data_d[k] = hist_data_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hist_vld_q <= '0;
      for (int k = 0; k < int'(HIST_D); k++) begin
        hist_dst_q[k]  <= '0;
        hist_data_q[k] <= '0;
      end
    end else begin
      hist_vld_q  <= hist_vld_d;
      hist_dst_q  <= hist_dst_d;
      hist_data_q <= hist_data_d;
    end
  end

  // Per-port select, youngest producer first; the first match decides data and pending state.
  always_comb begin : sel_comb
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic              found;
    bypass_c = '0;
    hit_c    = '0;
    pend_c   = '0;
    addr     = '0;
    data     = '0;
    found    = 1'b0;
    for (int p = 0; p < int'(N_RD); p++) begin
      addr  = rd_addr_i[p*REG_W +: REG_W];
      data  = rf_data_i[p*DATA_W +: DATA_W];
      found = 1'b0;
      for (int s = 0; s < int'(N_STG); s++) begin
        if (!found && stg_we_i[s] && (stg_dst_i[s*REG_W +: REG_W] == addr)) begin
          found     = 1'b1;
          data      = stg_data_i[s*DATA_W +: DATA_W];
          pend_c[p] = ~stg_rdy_i[s];
        end
      end
      if (!found && wb_we_i && (wb_dst_i == addr)) begin
        found = 1'b1;
        data  = wb_data_i;
      end
      for (int h = 0; h < int'(HIST_D); h++) begin
        if (!found && hist_vld_q[h] && (hist_dst_q[h] == addr)) begin
          found = 1'b1;
          data  = hist_data_q[h];
        end
      end
      if (addr == '0) begin
        found     = 1'b0;
        data      = '0;
        pend_c[p] = 1'b0;
      end
      hit_c[p]                     = found;
      bypass_c[p*DATA_W +: DATA_W] = data;
    end
  end

  assign bypass_o  = bypass_c;
  assign fwd_hit_o = hit_c;
  assign stall_o   = |pend_c;

`ifdef BYPASS_PERF_EN
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [SUM_W-1:0] fwd_sum;

  // Saturating counters; forwarded operands only count on non-stalled cycles.
  always_comb begin : perf_next
    fwd_sum     = {1'b0, fwd_cnt_q};
    stall_cnt_d = stall_cnt_q;
    if (!stall_o) begin
      for (int p = 0; p < int'(N_RD); p++) begin
        fwd_sum = fwd_sum + SUM_W'(hit_c[p]);
      end
    end
    fwd_cnt_d = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fwd_cnt_o   = fwd_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/bypass_net.md
Name: bypass_net

Overview:
- Parametrised operand-forwarding network for the exe stage.
- Generalises the single-source exe/wb forwarding mux to N_RD read ports and N_STG in-flight producer stages.
- Adds a writeback history buffer covering the register-file write-to-read latency, plus a stall request when the matching producer has not yet produced data.
- Sits between register-file read data and the ALU/branch/mem operand inputs.

Parameters:
- DATA_W, 64, operand width in bits.
- REG_W, 5, architectural register index width.
- N_RD, 2, number of operand read ports.
- N_STG, 3, in-flight producer stages; index 0 is youngest.
- HIST_D, 1, writeback history depth in cycles (1..4).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- rd_addr_i  in  N_RD*REG_W  source register index per port.
- rf_data_i  in  N_RD*DATA_W  register-file read data per port.
- stg_we_i  in  N_STG  stage holds an instruction that writes a register.
- stg_rdy_i  in  N_STG  stage result data is available (0 = load/mul pending).
- stg_dst_i  in  N_STG*REG_W  stage destination index.
- stg_data_i  in  N_STG*DATA_W  stage result.
- wb_we_i  in  1  writeback write enable.
- wb_dst_i  in  REG_W  writeback destination.
- wb_data_i  in  DATA_W  writeback data.
- bypass_o  out  N_RD*DATA_W  forwarded operand per port.
- fwd_hit_o  out  N_RD  port taken from a stage, writeback or history (not RF).
- stall_o  out  1  operand not yet available; exe must hold.

Behaviour:
- Per-port source selection is combinational, in priority order (youngest first):
  - stage 0 .. stage N_STG-1;
  - writeback;
  - history entry 0 (newest) .. HIST_D-1;
  - rf_data_i.
- A stage matches if stg_we_i=1 and stg_dst_i==rd_addr_i.
- Writeback matches if wb_we_i=1 and wb_dst_i==rd_addr_i.
- A history entry matches if its valid=1 and dst==rd_addr_i.
- Register x0 (rd_addr_i==0) never matches: bypass_o = 0 and fwd_hit_o = 0, regardless of rf_data_i.
- Only the highest-priority match counts. If that match is a stage with stg_rdy_i=0:
  - stall_o = 1 (OR across ports);
  - bypass_o for that port is don't-care; the bench must not check it.
  - Older matching stages are ignored; their data is stale.
- History buffer is a shift register of HIST_D entries {valid, dst, data}:
  - Each rising edge: entry0 <= {wb_we_i & (wb_dst_i!=0), wb_dst_i, wb_data_i}; entry k <= entry k-1.
  - Shifts every cycle, including while stall_o=1. A stall does not freeze writeback.
- Async reset (rstn_i=0):
  - All history valid bits cleared immediately; selection falls through to rf_data_i.
  - stall_o and fwd_hit_o are derived only from current inputs and cleared state.
  - Reset mid-operation discards history contents; no other state exists.
- Latency: zero cycles from inputs to bypass_o / stall_o; one cycle from writeback to history visibility.
- Multiple stages writing the same dst: the youngest wins. A port reading a register written by both wb and history takes wb.
- All comparisons are exact REG_W-bit; no widening or truncation of data.

Optional Feature:
- Macro BYPASS_PERF_EN.
- When defined, adds outputs:
  - perf_fwd_cnt_o (32 bits): +1 per cycle per port with fwd_hit_o=1 and stall_o=0; adds up to N_RD per cycle.
  - perf_stall_cnt_o (32 bits): +1 per cycle with stall_o=1.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0 on rstn_i=0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Stage priority: stage0 dst=5 data=0xAA rdy=1, stage2 dst=5 data=0xBB, rd_addr=5 → bypass_o=0xAA, fwd_hit=1, stall_o=0.
- Pending producer: stage0 dst=7 rdy=0, stage1 dst=7 data=0x11 rdy=1, rd_addr=7 → stall_o=1. Raise rdy with data 0x22 → bypass_o=0x22, stall_o=0.
- x0 guard: wb_we=1 wb_dst=0 data=0xFF, rf_data=0x33, rd_addr=0 → bypass_o=0, fwd_hit=0; next cycle the history entry stays invalid.
- History window: HIST_D=2, wb dst=9 data=0x1234 at cycle N, rf_data=0 → port reads 0x1234 at N, N+1 and N+2 (history); at N+3 reads rf_data.
- Async reset mid-stream: history holds dst=3 data=0x55, assert rstn_i=0 between edges → port reading 3 immediately returns rf_data_i=0x66.
- BYPASS_PERF_EN: 10 cycles with both ports forwarding plus 4 stall cycles → perf_fwd_cnt=20, perf_stall_cnt=4; preload near max → saturates at 0xFFFF_FFFF.
